// File: rtl/sys_feed_pkg.sv
// Shared types and constants for the 2x2 systolic operand feeder.
package sys_feed_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FEED      = 2'd1,
        FLUSH     = 2'd2,
        WAIT_DONE = 2'd3
    } feed_state_t;

    localparam int FEED_BEATS  = 3;
    localparam int FLUSH_BEATS = 2;
    localparam int DATA_W_DEF  = 32;

    localparam logic [1:0] FEED_LAST  = 2'(FEED_BEATS - 1);
    localparam logic [1:0] FLUSH_LAST = 2'(FLUSH_BEATS - 1);

endpackage

// File: rtl/sys_feed_skew.sv
// Beat-index to array-input selector: applies the diagonal skew to a 2x2
// operand pair. Row r carries A[r][t-r], column c carries B[t-c][c].
module sys_feed_skew
    import sys_feed_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic [1:0]        beat,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    output logic [DATA_W-1:0] row0,
    output logic [DATA_W-1:0] row1,
    output logic [DATA_W-1:0] col0,
    output logic [DATA_W-1:0] col1
);

    // Select the four skewed elements for the current beat; beat 3 is empty.
    always_comb begin
        row0 = '0;
        row1 = '0;
        col0 = '0;
        col1 = '0;
        case (beat)
            2'd0: begin
                row0 = a00;
                col0 = b00;
            end
            2'd1: begin
                row0 = a01;
                row1 = a10;
                col0 = b10;
                col1 = b01;
            end
            2'd2: begin
                row1 = a11;
                col1 = b11;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/systolic_feeder_2x2.sv
// Transmit side of the 2x2 systolic multiply: accepts one A/B operand pair,
// streams it skewed into the array, then waits for the array's done pulse.
// Optional build macro SYS_FEED_TIMEOUT_EN adds a WAIT_DONE dwell limit of
// TIMEOUT_CYCLES; without it the timeout output is held at 0.
//
// state     | meaning
// ----------+------------------------------------------------------------
// IDLE      | ready for an operand pair (in_ready high once out of reset)
// FEED      | three skewed operand beats, load_in high
// FLUSH     | two zero beats to drain the array, load_in high
// WAIT_DONE | waiting for arr_done (or dwell limit when enabled)
module systolic_feeder_2x2
    import sys_feed_pkg::*;
#(
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] a00,
    input  logic [DATA_W-1:0] a01,
    input  logic [DATA_W-1:0] a10,
    input  logic [DATA_W-1:0] a11,
    input  logic [DATA_W-1:0] b00,
    input  logic [DATA_W-1:0] b01,
    input  logic [DATA_W-1:0] b10,
    input  logic [DATA_W-1:0] b11,
    output logic [DATA_W-1:0] row_in_row0,
    output logic [DATA_W-1:0] row_in_row1,
    output logic [DATA_W-1:0] col_in_col0,
    output logic [DATA_W-1:0] col_in_col1,
    output logic              load_in,
    input  logic              arr_done,
    output logic              busy,
    output logic              feed_done,
    output logic              timeout
);

    feed_state_t state_q, state_n;
    logic [1:0]  beat_q, beat_n;
    logic        feed_done_n, timeout_n;
    logic        accept;

    logic [DATA_W-1:0] a00_q, a01_q, a10_q, a11_q;
    logic [DATA_W-1:0] b00_q, b01_q, b10_q, b11_q;
    logic [DATA_W-1:0] s_a00, s_a01, s_a10, s_a11;
    logic [DATA_W-1:0] s_b00, s_b01, s_b10, s_b11;
    logic [DATA_W-1:0] sk_row0, sk_row1, sk_col0, sk_col1;

    assign accept = in_valid && in_ready;

`ifdef SYS_FEED_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);
    logic [TMO_W-1:0] tmo_q;

    // Dwell counter: zero outside WAIT_DONE, counts cycles without arr_done.
    always_ff @(posedge clk) begin
        if (!rst)
            tmo_q <= '0;
        else if (state_q != WAIT_DONE)
            tmo_q <= '0;
        else if (!arr_done)
            tmo_q <= tmo_q + 1'b1;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

    // State and beat counter register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
        end else begin
            state_q <= state_n;
            beat_q  <= beat_n;
        end
    end

    // Next-state, beat sequencing and completion pulses.
    always_comb begin
        state_n     = state_q;
        beat_n      = beat_q;
        feed_done_n = 1'b0;
        timeout_n   = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_n = FEED;
                    beat_n  = '0;
                end
            end
            FEED: begin
                if (beat_q == FEED_LAST) begin
                    state_n = FLUSH;
                    beat_n  = '0;
                end else begin
                    beat_n = beat_q + 2'd1;
                end
            end
            FLUSH: begin
                if (beat_q == FLUSH_LAST) begin
                    state_n = WAIT_DONE;
                    beat_n  = '0;
                end else begin
                    beat_n = beat_q + 2'd1;
                end
            end
            WAIT_DONE: begin
                if (arr_done) begin
                    state_n     = IDLE;
                    feed_done_n = 1'b1;
                end
`ifdef SYS_FEED_TIMEOUT_EN
                else if (tmo_q == TMO_LAST) begin
                    state_n   = IDLE;
                    timeout_n = 1'b1;
                end
`endif
            end
            default: state_n = IDLE;
        endcase
    end

    // Operand capture on handshake; cleared by reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            {a00_q, a01_q, a10_q, a11_q} <= '0;
            {b00_q, b01_q, b10_q, b11_q} <= '0;
        end else if (accept) begin
            {a00_q, a01_q, a10_q, a11_q} <= {a00, a01, a10, a11};
            {b00_q, b01_q, b10_q, b11_q} <= {b00, b01, b10, b11};
        end
    end

    // The first beat is registered on the accept edge, before the capture
    // registers hold the new pair, so it is taken straight from the ports.
    always_comb begin
        if (state_q == IDLE) begin
            {s_a00, s_a01, s_a10, s_a11} = {a00, a01, a10, a11};
            {s_b00, s_b01, s_b10, s_b11} = {b00, b01, b10, b11};
        end else begin
            {s_a00, s_a01, s_a10, s_a11} = {a00_q, a01_q, a10_q, a11_q};
            {s_b00, s_b01, s_b10, s_b11} = {b00_q, b01_q, b10_q, b11_q};
        end
    end

    sys_feed_skew #(.DATA_W(DATA_W)) u_skew (
        .beat (beat_n),
        .a00  (s_a00),
        .a01  (s_a01),
        .a10  (s_a10),
        .a11  (s_a11),
        .b00  (s_b00),
        .b01  (s_b01),
        .b10  (s_b10),
        .b11  (s_b11),
        .row0 (sk_row0),
        .row1 (sk_row1),
        .col0 (sk_col0),
        .col1 (sk_col1)
    );

    // Registered outputs derived from the upcoming state.
    always_ff @(posedge clk) begin
        if (!rst) begin
            row_in_row0 <= '0;
            row_in_row1 <= '0;
            col_in_col0 <= '0;
            col_in_col1 <= '0;
            load_in     <= 1'b0;
            busy        <= 1'b0;
            in_ready    <= 1'b0;
            feed_done   <= 1'b0;
            timeout     <= 1'b0;
        end else begin
            row_in_row0 <= (state_n == FEED) ? sk_row0 : '0;
            row_in_row1 <= (state_n == FEED) ? sk_row1 : '0;
            col_in_col0 <= (state_n == FEED) ? sk_col0 : '0;
            col_in_col1 <= (state_n == FEED) ? sk_col1 : '0;
            load_in     <= (state_n == FEED) || (state_n == FLUSH);
            busy        <= (state_n != IDLE);
            in_ready    <= (state_n == IDLE);
            feed_done   <= feed_done_n;
            timeout     <= timeout_n;
        end
    end

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Self-checking bench for systolic_feeder_2x2. Expected beats come from the
// systolic diagonal rule (row r gets A[r][t-r], column c gets B[t-c][c]).
// Build with SYS_FEED_TIMEOUT_EN defined to exercise the dwell limit.
module tb_systolic_feeder_2x2;

    localparam int DW = 32;
`ifdef SYS_FEED_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 64;
`endif

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] a00, a01, a10, a11, b00, b01, b10, b11;
    logic [DW-1:0] row_in_row0, row_in_row1, col_in_col0, col_in_col1;
    logic          load_in;
    logic          arr_done;
    logic          busy;
    logic          feed_done;
    logic          timeout;

    systolic_feeder_2x2 #(.DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a00         (a00),
        .a01         (a01),
        .a10         (a10),
        .a11         (a11),
        .b00         (b00),
        .b01         (b01),
        .b10         (b10),
        .b11         (b11),
        .row_in_row0 (row_in_row0),
        .row_in_row1 (row_in_row1),
        .col_in_col0 (col_in_col0),
        .col_in_col1 (col_in_col1),
        .load_in     (load_in),
        .arr_done    (arr_done),
        .busy        (busy),
        .feed_done   (feed_done),
        .timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // matrices indexed [r*2+c]
    logic [DW-1:0] cur_a[4], cur_b[4], nxt_a[4], nxt_b[4];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_row(input int r, input int t);
        int k = t - r;
        if (k >= 0 && k < 2) return cur_a[r*2+k];
        return '0;
    endfunction

    function automatic logic [DW-1:0] exp_col(input int c, input int t);
        int k = t - c;
        if (k >= 0 && k < 2) return cur_b[k*2+c];
        return '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit use_nxt);
        a00 = use_nxt ? nxt_a[0] : cur_a[0];
        a01 = use_nxt ? nxt_a[1] : cur_a[1];
        a10 = use_nxt ? nxt_a[2] : cur_a[2];
        a11 = use_nxt ? nxt_a[3] : cur_a[3];
        b00 = use_nxt ? nxt_b[0] : cur_b[0];
        b01 = use_nxt ? nxt_b[1] : cur_b[1];
        b10 = use_nxt ? nxt_b[2] : cur_b[2];
        b11 = use_nxt ? nxt_b[3] : cur_b[3];
    endtask

    task automatic rand_cur();
        for (int i = 0; i < 4; i++) begin
            cur_a[i] = $urandom;
            cur_b[i] = $urandom;
        end
    endtask

    task automatic check_data_zero(input string tag);
        chk({tag, "_row0"}, row_in_row0, 0);
        chk({tag, "_row1"}, row_in_row1, 0);
        chk({tag, "_col0"}, col_in_col0, 0);
        chk({tag, "_col1"}, col_in_col1, 0);
    endtask

    task automatic apply_reset();
        rst      = 1'b0;
        in_valid = 1'b0;
        arr_done = 1'b0;
        tick();
        check_data_zero("rst");
        chk("rst_load", load_in, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_fdone", feed_done, 0);
        chk("rst_tmo", timeout, 0);
        rst = 1'b1;
        tick();
        chk("rel_ready", in_ready, 1);
        chk("rel_busy", busy, 0);
    endtask

    // d < 0: never answer with arr_done
    task automatic run_txn(input int d, input bit spur, input bit hold);
        chk("ready_pre", in_ready, 1);
        drive(0);
        in_valid = 1'b1;
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                nxt_a[i] = $urandom;
                nxt_b[i] = $urandom;
            end
        end
        for (int t = 0; t < 5; t++) begin
            tick();
            if (t == 0) begin
                if (hold) drive(1);
                else in_valid = 1'b0;
            end
            chk("beat_row0", row_in_row0, exp_row(0, t));
            chk("beat_row1", row_in_row1, exp_row(1, t));
            chk("beat_col0", col_in_col0, exp_col(0, t));
            chk("beat_col1", col_in_col1, exp_col(1, t));
            chk("beat_load", load_in, 1);
            chk("beat_busy", busy, 1);
            chk("beat_ready", in_ready, 0);
            chk("beat_fdone", feed_done, 0);
            chk("beat_tmo", timeout, 0);
            arr_done = spur ? 1'($urandom_range(0, 1)) : 1'b0;
        end
        tick();
        arr_done = 1'b0;
        chk("wait_load", load_in, 0);
        chk("wait_busy", busy, 1);
        chk("wait_fdone", feed_done, 0);
        check_data_zero("wait");
        if (d < 0) begin
`ifdef SYS_FEED_TIMEOUT_EN
            for (int j = 1; j < TMO; j++) begin
                tick();
                chk("dwell_tmo", timeout, 0);
                chk("dwell_busy", busy, 1);
            end
            tick();
            chk("tmo_pulse", timeout, 1);
            chk("tmo_fdone", feed_done, 0);
            chk("tmo_busy", busy, 0);
            chk("tmo_ready", in_ready, 1);
            tick();
            chk("tmo_once", timeout, 0);
`else
            bit bad = 1'b0;
            repeat (1000) begin
                tick();
                if (busy !== 1'b1 || timeout !== 1'b0) bad = 1'b1;
            end
            chk("hang_busy", busy, 1);
            chk("hang_tmo", timeout, 0);
            chk("hang_any", bad, 0);
            apply_reset();
`endif
        end else begin
            for (int j = 0; j < d; j++) begin
                tick();
                chk("dwell_fdone", feed_done, 0);
                chk("dwell_busy", busy, 1);
                chk("dwell_tmo", timeout, 0);
            end
            arr_done = 1'b1;
            tick();
            arr_done = 1'b0;
            chk("done_pulse", feed_done, 1);
            chk("done_tmo", timeout, 0);
            chk("done_busy", busy, 0);
            chk("done_ready", in_ready, 1);
            chk("done_load", load_in, 0);
        end
        if (hold) begin
            for (int i = 0; i < 4; i++) begin
                cur_a[i] = nxt_a[i];
                cur_b[i] = nxt_b[i];
            end
        end
    endtask

    initial begin
        bit held;
        int d;
        rst      = 1'b0;
        in_valid = 1'b0;
        arr_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cur_a[i] = '0;
            cur_b[i] = '0;
        end
        drive(0);
        apply_reset();

        // directed example
        cur_a[0] = 1; cur_a[1] = 2; cur_a[2] = 3; cur_a[3] = 4;
        cur_b[0] = 5; cur_b[1] = 6; cur_b[2] = 7; cur_b[3] = 8;
        run_txn(3, 0, 0);
        tick();
        chk("post_fdone", feed_done, 0);

        // back-to-back with spurious arr_done in the second
        rand_cur();
        run_txn(2, 0, 1);
        run_txn(4, 1, 0);

        // reset mid-feed
        rand_cur();
        drive(0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("mid_row0", row_in_row0, exp_row(0, 0));
        tick();
        chk("mid_row1", row_in_row1, exp_row(1, 1));
        apply_reset();
        tick();
        chk("mid_nodone", feed_done, 0);
        rand_cur();
        run_txn(1, 0, 0);

        // randomized transactions
        held = 1'b0;
        for (int n = 0; n < 10; n++) begin
            bit hold;
            if (!held) begin
                rand_cur();
                repeat ($urandom_range(0, 2)) begin
                    tick();
                    chk("idle_ready", in_ready, 1);
                end
            end
`ifdef SYS_FEED_TIMEOUT_EN
            d = $urandom_range(0, TMO - 1);
`else
            d = $urandom_range(0, 10);
`endif
            hold = 1'($urandom_range(0, 1));
            run_txn(d, 1'($urandom_range(0, 1)), hold);
            held = hold;
        end

`ifdef SYS_FEED_TIMEOUT_EN
        // arr_done coincident with the last dwell cycle
        if (!held) rand_cur();
        run_txn(TMO - 1, 0, 0);
        held = 1'b0;
`endif
        if (!held) rand_cur();
        run_txn(-1, 0, 0);
        rand_cur();
        run_txn(0, 1, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
